dvi_link_sequencer: RTL and testbench



---
 rtl/dvi_link_sequencer.sv | 149 ++++++++++++++
 tb/tb_dvi_link_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dvi_link_sequencer.sv
// dvi_link_sequencer
// Bring-up and supervision controller for the TMDS serializer datapath.
// Holds the serializer in reset until lock and enable have been stable for
// SETTLE_CYCLES edges, sends control tokens for BLANK_CYCLES edges, then
// passes pixel symbols through starting on the first frame_start_i pulse.
// Losing lock or enable returns the link to reset and blanking.
// Lock losses while ACTIVE are counted (saturating) for debug.
//
// Handshake: there is no valid/ready flow control on this block.
// Symbols are sampled on every edge. frame_start_i is a single-cycle pulse
// coincident with the first symbol of a frame. It is only acted on in
// WAIT_FRAME.
module dvi_link_sequencer #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int BLANK_CYCLES  = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       locked_i,
    input  logic       enable_i,
    input  logic       frame_start_i,
    input  logic [9:0] symbol_red_i,
    input  logic [9:0] symbol_green_i,
    input  logic [9:0] symbol_blue_i,
    output logic [9:0] symbol_red_o,
    output logic [9:0] symbol_green_o,
    output logic [9:0] symbol_blue_o,
    output logic       oserdes_reset_o,
    output logic       link_up_o,
    output logic [7:0] restart_count_o,
    output logic [1:0] state_o
);

    // DVI control token for C1C0=00, identical on all three channels
    localparam logic [9:0] TOK = 10'h354;

    localparam int MAX_CYC = (SETTLE_CYCLES > BLANK_CYCLES) ? SETTLE_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_BLANK      = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_ACTIVE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       restart_q, restart_d;
    logic [9:0]       red_q, red_d;
    logic [9:0]       green_q, green_d;
    logic [9:0]       blue_q, blue_d;
    logic             ser_rst_q, ser_rst_d;
    logic             link_up_q, link_up_d;
    logic             qualified;

    // Next-state, counter and output computation.
    // Outputs are derived from the next state, so every output is a register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        restart_d = restart_q;
        qualified = locked_i && enable_i;

        if (!qualified) begin
            // Abort: any lock or enable loss drops straight back to reset hold
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
            if ((state_q == ST_ACTIVE) && !locked_i && (restart_q != 8'hFF)) begin
                restart_d = restart_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_BLANK: begin
                    // frame_start_i is deliberately ignored here, including the last edge
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_WAIT_FRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start_i) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    state_d = ST_ACTIVE;
                end
                default: begin
                    state_d = ST_RESET_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        ser_rst_d = (state_d == ST_RESET_HOLD);
        link_up_d = (state_d == ST_ACTIVE);
        // The frame's first symbol is loaded on the same edge that enters ACTIVE
        red_d     = link_up_d ? symbol_red_i   : TOK;
        green_d   = link_up_d ? symbol_green_i : TOK;
        blue_d    = link_up_d ? symbol_blue_i  : TOK;
    end

    // State, counter and registered outputs with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_RESET_HOLD;
            cnt_q     <= '0;
            restart_q <= 8'd0;
            red_q     <= TOK;
            green_q   <= TOK;
            blue_q    <= TOK;
            ser_rst_q <= 1'b1;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            ser_rst_q <= ser_rst_d;
            link_up_q <= link_up_d;
        end
    end

    assign symbol_red_o    = red_q;
    assign symbol_green_o  = green_q;
    assign symbol_blue_o   = blue_q;
    assign oserdes_reset_o = ser_rst_q;
    assign link_up_o       = link_up_q;
    assign restart_count_o = restart_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// Testbench for dvi_link_sequencer with SETTLE_CYCLES=8 and BLANK_CYCLES=4.
// A behavioural model tracks the run of qualifying edges and ACTIVE status.
// Every cycle it queues the expected output word.
// Directed scenarios add literal checks that pin the model.
module tb_dvi_link_sequencer;
  localparam int S = 8;
  localparam int B = 4;
  localparam int W = 41;
  localparam logic [9:0] TOK = 10'h354;

  logic       clk;
  logic       reset_i;
  logic       locked_i;
  logic       enable_i;
  logic       frame_start_i;
  logic [9:0] red_i, green_i, blue_i;
  logic [9:0] red_o, green_o, blue_o;
  logic       oserdes_reset_o;
  logic       link_up_o;
  logic [7:0] restart_count_o;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  dvi_link_sequencer #(
    .SETTLE_CYCLES(S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .locked_i(locked_i),
    .enable_i(enable_i),
    .frame_start_i(frame_start_i),
    .symbol_red_i(red_i),
    .symbol_green_i(green_i),
    .symbol_blue_i(blue_i),
    .symbol_red_o(red_o),
    .symbol_green_o(green_o),
    .symbol_blue_o(blue_o),
    .oserdes_reset_o(oserdes_reset_o),
    .link_up_o(link_up_o),
    .restart_count_o(restart_count_o),
    .state_o(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", name, got, exp);
  endtask

  // behavioural model
  // run: consecutive qualifying edges since the last abort or reset.
  // act: link carrying pixels.
  int       run  = 0;
  bit       act  = 1'b0;
  int       rc_m = 0;
  logic     m_rst;
  logic [W-1:0] m_word;

  always @(posedge clk) begin
    if (reset_i) begin
      run = 0; act = 1'b0; rc_m = 0;
    end else if (!(locked_i && enable_i)) begin
      if (act && !locked_i && rc_m < 255) rc_m++;
      run = 0; act = 1'b0;
    end else begin
      // edges 1..S settle, S+1..S+B blank, frame accepted from edge S+B+1
      if (!act && run >= S + B && frame_start_i) act = 1'b1;
      if (run < 100000) run++;
    end
    m_rst  = !act && (run < S);
    m_word = {rc_m[7:0], act, m_rst,
              act ? red_i : TOK, act ? green_i : TOK, act ? blue_i : TOK};
    exp_q.push_back(m_word);
  end

  // scoreboard compare process
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("outputs", {23'd0, restart_count_o, link_up_o, oserdes_reset_o, red_o, green_o, blue_o},
            {23'd0, e});
    end
  end

  // driver tasks
  task automatic tick_sym(input bit rst, input bit fs, input bit lk, input bit en,
                          input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    reset_i = rst; frame_start_i = fs; locked_i = lk; enable_i = en;
    red_i = r; green_i = g; blue_i = b;
    @(posedge clk);
    #1;
    frame_start_i = 1'b0;
  endtask

  task automatic tick(input bit fs, input bit lk, input bit en);
    tick_sym(1'b0, fs, lk, en, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
             10'($urandom_range(0, 1023)));
  endtask

  task automatic do_reset();
    tick_sym(1'b1, 1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
  endtask

  task automatic bring_up();
    int extra;
    for (int i = 0; i < S + B; i++) tick(1'b0, 1'b1, 1'b1);
    extra = $urandom_range(0, 2);
    for (int i = 0; i < extra; i++) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
  endtask

  task automatic check_idle(input string name, input logic [7:0] rc);
    check({name, "_rst"}, oserdes_reset_o, 1'b1);
    check({name, "_link"}, link_up_o, 1'b0);
    check({name, "_sym"}, {red_o, green_o, blue_o}, {TOK, TOK, TOK});
    check({name, "_rc"}, restart_count_o, rc);
  endtask

  initial begin
    reset_i = 1'b1; locked_i = 1'b1; enable_i = 1'b1; frame_start_i = 1'b0;
    red_i = '0; green_i = '0; blue_i = '0;
    do_reset();
    do_reset();
    check_idle("reset", 8'd0);

    // 1: settle count with lock held
    for (int i = 0; i < S - 1; i++) tick(1'b0, 1'b1, 1'b1);
    check("settle7_rst", oserdes_reset_o, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("settle8_rst", oserdes_reset_o, 1'b0);
    check("settle8_link", link_up_o, 1'b0);
    check("settle8_sym", red_o, TOK);

    // 2: lock glitch restarts the count
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < S - 1; i++) tick(1'b0, 1'b1, 1'b1);
    check("gap_rst_held", oserdes_reset_o, 1'b1);
    check("gap_rc", restart_count_o, 8'd0);
    tick(1'b0, 1'b1, 1'b1);
    check("gap_release", oserdes_reset_o, 1'b0);

    // 3: frame_start during BLANK ignored (second and last blank edge)
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("blank_fs_ignored", link_up_o, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    check("wait_link", link_up_o, 1'b0);
    tick_sym(1'b0, 1'b1, 1'b1, 1'b1, 10'h2AB, 10'h155, 10'h0FF);
    check("first_sym", {red_o, green_o, blue_o}, {10'h2AB, 10'h155, 10'h0FF});
    check("first_link", link_up_o, 1'b1);
    tick_sym(1'b0, 1'b0, 1'b1, 1'b1, 10'h001, 10'h200, 10'h3C3);
    check("pass_sym", {red_o, green_o, blue_o}, {10'h001, 10'h200, 10'h3C3});

    // 4a: lock loss in ACTIVE
    tick(1'b0, 1'b0, 1'b1);
    check_idle("lockloss1", 8'd1);
    // frame_start with lock low takes the abort path
    bring_up();
    tick(1'b1, 1'b0, 1'b1);
    check_idle("lockloss2", 8'd2);
    bring_up();
    tick(1'b0, 1'b0, 1'b1);
    check("rc3", restart_count_o, 8'd3);

    // 5: disable-only abort does not count; full re-bring-up required
    bring_up();
    tick(1'b0, 1'b1, 1'b0);
    check_idle("disable", 8'd3);
    for (int i = 0; i < S + B; i++) tick(1'b0, 1'b1, 1'b1);
    check("reenable_wait", link_up_o, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    check("reenable_link", link_up_o, 1'b1);

    // 6: reset mid-ACTIVE clears everything
    check("pre_reset_rc", restart_count_o, 8'd3);
    do_reset();
    check_idle("midreset", 8'd0);

    // 4b: 300 lock losses saturate the counter
    for (int n = 0; n < 300; n++) begin
      bring_up();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, $urandom_range(0, 1) == 1);
      if (n == 254) check("rc255", restart_count_o, 8'd255);
    end
    check("rc_sat", restart_count_o, 8'd255);

    // randomized soak against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick_sym($urandom_range(0, 999) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 79) != 0, $urandom_range(0, 119) != 0,
               10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
               10'($urandom_range(0, 1023)));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
